// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and syndrome bit positions for the exception sequencer
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        REDIRECT,
        HANDLER,
        RETURN
    } exc_state_e;

    localparam int ESR_W      = 4;
    localparam int CNT_W      = 4;

    localparam int ESR_BADOP  = 0;
    localparam int ESR_EXTI   = 1;
    localparam int ESR_DFAULT = 3;

    // New cause word: the sticky double-fault bit survives, causes are replaced.
    function automatic logic [ESR_W-1:0] esr_with_cause(input logic [ESR_W-1:0] esr,
                                                        input int              cause);
        logic [ESR_W-1:0] r;
        r              = '0;
        r[ESR_DFAULT]  = esr[ESR_DFAULT];
        r[cause]       = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/flopre.sv
// rtl/flopre.sv - enable register with asynchronous active-low reset
module flopre #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - LEGv8 exception/interrupt sequencer driving fetch redirect
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int           N         = 64,
    parameter logic [N-1:0] EV_BASE   = N'(64'h0000_0000_0000_00D8),
    parameter int           FLUSH_CYC = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         BadOp_in,
    input  logic [N-1:0] BadOpPC_in,
    input  logic         ExtI_in,
    input  logic [N-1:0] IntPC_in,
    input  logic         ERet_in,
    output logic         EProc_F,
    output logic [N-1:0] EVAddr_F,
    output logic         Flush_out,
    output logic         ExcAck_out,
    output logic [N-1:0] ELR_out,
    output logic [3:0]   ESR_out,
    output logic         InHandler_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);

    exc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             elr_en;
    logic [N-1:0]     elr_d, elr_q;
    logic             esr_en;
    logic [ESR_W-1:0] esr_d, esr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    flopre #(.W(N)) u_elr (
        .clk   (clk),
        .reset (reset),
        .en    (elr_en),
        .d     (elr_d),
        .q     (elr_q)
    );

    flopre #(.W(ESR_W)) u_esr (
        .clk   (clk),
        .reset (reset),
        .en    (esr_en),
        .d     (esr_d),
        .q     (esr_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        elr_en  = 1'b0;
        elr_d   = elr_q;
        esr_en  = 1'b0;
        esr_d   = esr_q;

        unique case (state_q)
            IDLE: begin
                // Bad opcode has priority; a level interrupt simply waits for return.
                if (BadOp_in) begin
                    elr_en  = 1'b1;
                    elr_d   = BadOpPC_in;
                    esr_en  = 1'b1;
                    esr_d   = esr_with_cause(esr_q, ESR_BADOP);
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else if (ExtI_in) begin
                    elr_en  = 1'b1;
                    elr_d   = IntPC_in;
                    esr_en  = 1'b1;
                    esr_d   = esr_with_cause(esr_q, ESR_EXTI);
                    cnt_d   = '0;
                    state_d = FLUSH;
                end
            end

            FLUSH: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = REDIRECT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            REDIRECT: begin
                state_d = HANDLER;
            end

            HANDLER: begin
                // Nested faults are only recorded; the running handler keeps its ELR.
                if (BadOp_in) begin
                    esr_en             = 1'b1;
                    esr_d[ESR_DFAULT]  = 1'b1;
                end
                if (ERet_in) begin
                    state_d = RETURN;
                end
            end

            RETURN: begin
                esr_en              = 1'b1;
                esr_d[ESR_BADOP]    = 1'b0;
                esr_d[ESR_EXTI]     = 1'b0;
                state_d             = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        EProc_F       = 1'b0;
        EVAddr_F      = '0;
        Flush_out     = 1'b0;
        ExcAck_out    = 1'b0;
        InHandler_out = 1'b0;

        unique case (state_q)
            FLUSH: begin
                Flush_out = 1'b1;
            end
            REDIRECT: begin
                EProc_F    = 1'b1;
                EVAddr_F   = EV_BASE;
                Flush_out  = 1'b1;
                ExcAck_out = esr_q[ESR_EXTI];
            end
            HANDLER: begin
                InHandler_out = 1'b1;
            end
            RETURN: begin
                EProc_F   = 1'b1;
                EVAddr_F  = elr_q;
                Flush_out = 1'b1;
            end
            default: begin
                EProc_F = 1'b0;
            end
        endcase
    end

    assign ELR_out = elr_q;
    assign ESR_out = esr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - randomized self-checking bench for exc_ctrl against a timeline model
module tb_exc_ctrl;

    localparam int          N  = 64;
    localparam logic [63:0] EV = 64'h0000_0000_0000_00D8;
    localparam int          F  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        BadOp_in = 1'b0;
    logic [63:0] BadOpPC_in = '0;
    logic        ExtI_in = 1'b0;
    logic [63:0] IntPC_in = '0;
    logic        ERet_in = 1'b0;
    logic        EProc_F;
    logic [63:0] EVAddr_F;
    logic        Flush_out;
    logic        ExcAck_out;
    logic [63:0] ELR_out;
    logic [3:0]  ESR_out;
    logic        InHandler_out;

    always #5 clk = ~clk;

    exc_ctrl #(.N(N), .EV_BASE(EV), .FLUSH_CYC(F)) dut (
        .clk           (clk),
        .reset         (reset),
        .BadOp_in      (BadOp_in),
        .BadOpPC_in    (BadOpPC_in),
        .ExtI_in       (ExtI_in),
        .IntPC_in      (IntPC_in),
        .ERet_in       (ERet_in),
        .EProc_F       (EProc_F),
        .EVAddr_F      (EVAddr_F),
        .Flush_out     (Flush_out),
        .ExcAck_out    (ExcAck_out),
        .ELR_out       (ELR_out),
        .ESR_out       (ESR_out),
        .InHandler_out (InHandler_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Timeline model: m_age counts cycles since an exception was accepted
    // (1..F flushing, F+1 redirecting, 0 otherwise).
    int          m_age;
    bit          m_hand;
    bit          m_ret;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;
    bit          e_ack;

    task automatic model_reset();
        m_age  = 0;
        m_hand = 0;
        m_ret  = 0;
        m_elr  = '0;
        m_esr  = '0;
        e_ack  = 0;
    endtask

    task automatic step(input bit bo, input logic [63:0] bpc, input bit ei,
                        input logic [63:0] ipc, input bit er);
        bit          redir;
        logic [63:0] e_va;
        @(negedge clk);
        redir = (m_age == F + 1);
        e_va  = redir ? EV : (m_ret ? m_elr : 64'h0);
        e_ack = redir && m_esr[1];
        chk("flush",   {63'h0, Flush_out},     {63'h0, (m_age > 0) || m_ret});
        chk("eproc",   {63'h0, EProc_F},       {63'h0, redir || m_ret});
        chk("evaddr",  EVAddr_F,               e_va);
        chk("ack",     {63'h0, ExcAck_out},    {63'h0, e_ack});
        chk("inhand",  {63'h0, InHandler_out}, {63'h0, m_hand});
        chk("elr",     ELR_out,                m_elr);
        chk("esr",     {60'h0, ESR_out},       {60'h0, m_esr});

        BadOp_in   = bo;
        BadOpPC_in = bpc;
        ExtI_in    = ei;
        IntPC_in   = ipc;
        ERet_in    = er;

        if (m_ret) begin
            m_ret      = 0;
            m_esr[1:0] = 2'b00;
        end else if (m_age > 0) begin
            if (m_age == F + 1) begin
                m_age  = 0;
                m_hand = 1;
            end else begin
                m_age++;
            end
        end else if (m_hand) begin
            if (bo) m_esr[3] = 1'b1;
            if (er) begin
                m_hand = 0;
                m_ret  = 1;
            end
        end else if (bo) begin
            m_elr = bpc;
            m_esr = {m_esr[3], 3'b001};
            m_age = 1;
        end else if (ei) begin
            m_elr = ipc;
            m_esr = {m_esr[3], 3'b010};
            m_age = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        BadOp_in = 0;
        ExtI_in  = 0;
        ERet_in  = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_flush",  {63'h0, Flush_out},     64'h0);
        chk("rst_eproc",  {63'h0, EProc_F},       64'h0);
        chk("rst_evaddr", EVAddr_F,               64'h0);
        chk("rst_ack",    {63'h0, ExcAck_out},    64'h0);
        chk("rst_inhand", {63'h0, InHandler_out}, 64'h0);
        chk("rst_elr",    ELR_out,                64'h0);
        chk("rst_esr",    {60'h0, ESR_out},       64'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    bit          ei_hold;
    logic [63:0] rpc;

    initial begin
        model_reset();
        async_reset();
        idle(10);

        // Bad opcode, then return.
        step(1, 64'h40, 0, '0, 0);
        idle(7);
        step(0, '0, 0, '0, 1);
        idle(3);

        // Interrupt held until acknowledge, then return.
        for (int i = 0; i < 5; i++) step(0, '0, 1, 64'h100, 0);
        idle(4);
        step(0, '0, 0, '0, 1);
        idle(3);

        // Simultaneous: bad opcode first, interrupt taken after return.
        step(1, 64'h40, 1, 64'h200, 0);
        for (int i = 0; i < 6; i++) step(0, '0, 1, 64'h200, 0);
        step(0, '0, 1, 64'h200, 1);
        for (int i = 0; i < 6; i++) step(0, '0, 1, 64'h200, 0);
        idle(3);
        step(0, '0, 0, '0, 1);
        idle(3);

        // Double fault inside the handler; sticky bit survives return.
        step(1, 64'h300, 0, '0, 0);
        idle(6);
        step(1, 64'hDEAD, 0, '0, 0);
        idle(2);
        step(0, '0, 0, '0, 1);
        idle(3);

        // Reset during the second flush cycle.
        step(1, 64'h80, 0, '0, 0);
        step(0, '0, 0, '0, 0);
        async_reset();
        idle(10);

        // Randomized traffic with level-held interrupts.
        ei_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!ei_hold && ($urandom_range(0, 19) == 0)) ei_hold = 1;
            rpc = {$urandom, $urandom};
            step(($urandom_range(0, 11) == 0), {$urandom, $urandom}, ei_hold, rpc,
                 ($urandom_range(0, 5) == 0));
            if (e_ack) ei_hold = 0;
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
                ei_hold = 0;
            end
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
